// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: holds the PC, issues in-order imem fetches, queues responses
// and drops responses that belong to a path abandoned by a redirect.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_data,
  output logic [31:0] fetch_pc
);
  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH = CW'(QDEPTH);
  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  logic [1:0]    state;
  logic [CW-1:0] inflight, drop_cnt, q_cnt, inflight_nxt, drop_nxt;
  logic [AW-1:0] p_head, p_tail, q_head, q_tail;
  logic [31:0]   p_pc   [QDEPTH];
  logic [31:0]   q_pc   [QDEPTH];
  logic [31:0]   q_data [QDEPTH];
  logic          req_fire, pop, keep;
  // a request slot is only offered while a queue entry is guaranteed for its response
  assign imem_req_valid = state == S_FETCH && inflight + q_cnt < DEPTH;
  assign imem_req_addr  = fetch_pc;
  assign inst_valid     = q_cnt != '0;
  assign inst_pc        = inst_valid ? q_pc[q_head] : '0;
  assign inst_data      = inst_valid ? q_data[q_head] : '0;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign pop            = inst_valid && inst_ready;
  assign keep           = imem_rsp_valid && drop_cnt == '0 && !redirect_valid;
  always_comb begin
    inflight_nxt = inflight + CW'(req_fire) - CW'(imem_rsp_valid);
    drop_nxt     = redirect_valid ? inflight_nxt : drop_cnt - CW'(imem_rsp_valid && drop_cnt != '0);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_BOOT;
      fetch_pc <= RESET_PC;
      inflight <= '0;
      drop_cnt <= '0;
      q_cnt    <= '0;
      q_head   <= '0;
      q_tail   <= '0;
      p_head   <= '0;
      p_tail   <= '0;
    end else begin
      state    <= redirect_valid ? (drop_nxt != '0 ? S_FLUSH : S_FETCH)
                : (state == S_BOOT || (state == S_FLUSH && drop_nxt == '0)) ? S_FETCH : state;
      fetch_pc <= redirect_valid ? redirect_pc & ~32'd3 : req_fire ? fetch_pc + 32'd4 : fetch_pc;
      inflight <= inflight_nxt;
      drop_cnt <= drop_nxt;
      p_tail   <= p_tail + AW'(req_fire);
      p_head   <= p_head + AW'(imem_rsp_valid);
      q_cnt    <= redirect_valid ? '0 : q_cnt + CW'(keep) - CW'(pop);
      q_head   <= redirect_valid ? '0 : q_head + AW'(pop);
      q_tail   <= redirect_valid ? '0 : q_tail + AW'(keep);
    end
  end
  always_ff @(posedge clk) begin
    if (req_fire) p_pc[p_tail] <= fetch_pc;
    if (keep) begin
      q_pc[q_tail]   <= p_pc[p_head];
      q_data[q_tail] <= imem_rsp_data;
    end
  end
  assert property (@(posedge clk) disable iff (!rst_n)
    {1'b0, inflight} + {1'b0, q_cnt} <= {1'b0, DEPTH});
endmodule
